// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the button debouncer and its synchronizer.
// DEFAULT_* values suit simulation; BOARD_* values suit a 100 MHz board clock.
package debounce_pkg;

  localparam int unsigned DEFAULT_STABLE_CYCLES = 4;
  localparam int unsigned BOARD_STABLE_CYCLES   = 1_000_000;  // 10 ms at 100 MHz
  localparam int unsigned DEFAULT_SYNC_STAGES   = 2;

  // Width of a counter that must hold 0..max_count.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchronizer for one asynchronous level.
// Synchronous active-low reset clears every stage to 0.
module sync_ff
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronize, require STABLE_CYCLES of disagreement, then follow.
// Define DEBOUNCE_PULSE_EN to add registered btn_press / btn_release edge pulses.
module btn_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_out
`ifdef DEBOUNCE_PULSE_EN
  ,
  output logic btn_press,
  output logic btn_release
`endif
);

  localparam int unsigned CntW = cnt_width(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

  logic            sync;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            out_q, out_d;

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_in),
    .q  (sync)
  );

  // Any cycle where sync agrees with the output throws away the partial count.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (sync == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      out_d = sync;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign btn_out = out_q;

`ifdef DEBOUNCE_PULSE_EN
  logic press_q, release_q;

  // Computed from out_d so the pulse lands in the same cycle btn_out changes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= out_d & ~out_q;
      release_q <= ~out_d & out_q;
    end
  end

  assign btn_press   = press_q;
  assign btn_release = release_q;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed vector table, hand sequences,
// and randomized stimulus against a sliding-window reference model.
module tb_btn_debounce;

  localparam int unsigned STABLE = 4;
  localparam int unsigned SYNCN  = 2;

  logic clk;
  logic rst;
  logic btn_in;
  logic btn_out;
  logic btn_press;
  logic btn_release;

  btn_debounce #(
    .STABLE_CYCLES(STABLE),
    .SYNC_STAGES  (SYNCN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_out    (btn_out)
`ifdef DEBOUNCE_PULSE_EN
    ,
    .btn_press  (btn_press),
    .btn_release(btn_release)
`endif
  );

`ifndef DEBOUNCE_PULSE_EN
  assign btn_press   = 1'b0;
  assign btn_release = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, got, exp);
    end
  endtask

  // Reference model: the input seen at the comparison point is btn_in delayed by
  // SYNCN edges; the output flips once the last STABLE such samples all disagree.
  logic m_pipe[$];
  logic m_win[$];
  logic m_out   = 1'b0;
  logic m_press = 1'b0;
  logic m_rel   = 1'b0;

  initial begin
    for (int i = 0; i < int'(SYNCN); i++) m_pipe.push_back(1'b0);
  end

  always @(posedge clk) begin
    logic seen;
    logic prev;
    logic all_diff;
    prev = m_out;
    if (!rst) begin
      for (int i = 0; i < int'(SYNCN); i++) m_pipe[i] = 1'b0;
      m_win.delete();
      m_out   = 1'b0;
      m_press = 1'b0;
      m_rel   = 1'b0;
    end else begin
      seen = m_pipe[0];
      void'(m_pipe.pop_front());
      m_pipe.push_back(btn_in);
      m_win.push_back(seen);
      if (m_win.size() > int'(STABLE)) void'(m_win.pop_front());
      all_diff = (m_win.size() == int'(STABLE));
      foreach (m_win[k]) if (m_win[k] == m_out) all_diff = 1'b0;
      if (all_diff) m_out = seen;
      m_press = m_out & ~prev;
      m_rel   = ~m_out & prev;
    end
  end

  typedef struct {
    logic r;
    logic b;
    logic exp_out;
    logic exp_press;
    logic exp_rel;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic b, input logic o, input logic p,
                     input logic l, input int n);
    vec_t v;
    v.r = r; v.b = b; v.exp_out = o; v.exp_press = p; v.exp_rel = l;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic b);
    rst    = r;
    btn_in = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst    = 1'b0;
    btn_in = 1'b0;

    // Reset with button held high, then settle low.
    add(0, 1, 0, 0, 0, 3);
    add(1, 0, 0, 0, 0, 4);
    // Clean press: rises on edge 6.
    add(1, 1, 0, 0, 0, 5);
    add(1, 1, 1, 1, 0, 1);
    add(1, 1, 1, 0, 0, 14);
    // Release: falls on edge 6.
    add(1, 0, 1, 0, 0, 5);
    add(1, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 14);
    // 3-cycle high glitch rejected.
    add(1, 1, 0, 0, 0, 3);
    add(1, 0, 0, 0, 0, 8);
    // Bouncy press: 1,0,1,0 in 2-cycle chunks, then hold.
    add(1, 1, 0, 0, 0, 2);
    add(1, 0, 0, 0, 0, 2);
    add(1, 1, 0, 0, 0, 2);
    add(1, 0, 0, 0, 0, 2);
    add(1, 1, 0, 0, 0, 5);
    add(1, 1, 1, 1, 0, 1);
    add(1, 1, 1, 0, 0, 6);
    // 3-cycle low glitch while pressed rejected.
    add(1, 0, 1, 0, 0, 3);
    add(1, 1, 1, 0, 0, 8);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].b);
      check("tbl_out", i, 32'(btn_out), 32'(vecs[i].exp_out));
`ifdef DEBOUNCE_PULSE_EN
      check("tbl_press", i, 32'(btn_press), 32'(vecs[i].exp_press));
      check("tbl_release", i, 32'(btn_release), 32'(vecs[i].exp_rel));
`endif
    end
    check("glitch_cnt", 0, 32'(dut.cnt_q), 32'd0);

    // Reset while btn_out is high clears output and pulses.
    drive(0, 1);
    check("rst_hi_out", 0, 32'(btn_out), 32'd0);
    check("rst_hi_press", 0, 32'(btn_press), 32'd0);
    check("rst_hi_rel", 0, 32'(btn_release), 32'd0);
    repeat (10) drive(1, 0);
    check("pre_mid_out", 0, 32'(btn_out), 32'd0);

    // Mid-count reset: counter at 2 after 4 edges, then cleared by reset.
    repeat (4) drive(1, 1);
    check("mid_cnt", 0, 32'(dut.cnt_q), 32'd2);
    check("mid_out", 0, 32'(btn_out), 32'd0);
    repeat (2) drive(0, 1);
    check("mid_rst_cnt", 0, 32'(dut.cnt_q), 32'd0);
    check("mid_rst_out", 0, 32'(btn_out), 32'd0);
    for (int e = 1; e <= 6; e++) begin
      drive(1, 1);
      check("post_rst_out", e, 32'(btn_out), (e == 6) ? 32'd1 : 32'd0);
    end

    // Randomized levels and hold lengths with occasional resets, vs. the model.
    for (int i = 0; i < 300; i++) begin
      logic lvl;
      int   hold;
      lvl  = 1'($urandom_range(0, 1));
      hold = int'($urandom_range(1, 8));
      for (int h = 0; h < hold; h++) begin
        drive(($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1, lvl);
        check("rnd_out", i, 32'(btn_out), 32'(m_out));
`ifdef DEBOUNCE_PULSE_EN
        check("rnd_press", i, 32'(btn_press), 32'(m_press));
        check("rnd_release", i, 32'(btn_release), 32'(m_rel));
`endif
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
